// File: rtl/cmp_pipe.sv
// Two-stage pipelined SLT/SLTU (and optional signed MIN/MAX) compare unit with valid/ready handshake.
// Optional feature: define CMP_MINMAX_EN to decode in_op[2] (MIN) and in_op[3] (MAX).
module cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid_reg;
    logic [3:0]       s1_op_reg;
    logic [WIDTH-1:0] s1_src1_reg;
    logic [WIDTH-1:0] s1_src2_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_result_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    logic             s1_adv;
    logic             s2_adv;

    assign s2_adv   = ~s2_valid_reg | out_ready;
    assign s1_adv   = ~s1_valid_reg | s2_adv;
    assign in_ready = s1_adv & ~flush;

    // src1 - src2 as src1 + ~src2 + 1; the carry out is the unsigned no-borrow flag.
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             lt_u;
    logic             lt_s;
    logic             msb1;
    logic             msb2;

    assign sub_full = {1'b0, s1_src1_reg} + {1'b0, ~s1_src2_reg} + {{WIDTH{1'b0}}, 1'b1};
    assign diff     = sub_full[WIDTH-1:0];
    assign cout     = sub_full[WIDTH];
    assign msb1     = s1_src1_reg[WIDTH-1];
    assign msb2     = s1_src2_reg[WIDTH-1];
    assign lt_u     = ~cout;
    assign lt_s     = (msb1 & ~msb2) | (~(msb1 ^ msb2) & diff[WIDTH-1]);

    logic [WIDTH-1:0] result_next;

`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;

    assign min_val = lt_s ? s1_src1_reg : s1_src2_reg;
    assign max_val = lt_s ? s1_src2_reg : s1_src1_reg;
`else
    logic unused_op_bits;

    assign unused_op_bits = ^s1_op_reg[3:2];
`endif

    // Multi-hot ops OR their individual results together.
    always_comb begin
        result_next = '0;
        if (s1_op_reg[0]) begin
            result_next = result_next | {{(WIDTH-1){1'b0}}, lt_s};
        end
        if (s1_op_reg[1]) begin
            result_next = result_next | {{(WIDTH-1){1'b0}}, lt_u};
        end
`ifdef CMP_MINMAX_EN
        if (s1_op_reg[2]) begin
            result_next = result_next | min_val;
        end
        if (s1_op_reg[3]) begin
            result_next = result_next | max_val;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_reg  <= 1'b0;
            s1_op_reg     <= '0;
            s1_src1_reg   <= '0;
            s1_src2_reg   <= '0;
            s1_tag_reg    <= '0;
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_tag_reg    <= '0;
        end else begin
            if (flush) begin
                s1_valid_reg <= 1'b0;
            end else if (s1_adv) begin
                s1_valid_reg <= in_valid;
            end

            if (s1_adv && in_valid && !flush) begin
                s1_op_reg   <= in_op;
                s1_src1_reg <= in_src1;
                s1_src2_reg <= in_src2;
                s1_tag_reg  <= in_tag;
            end

            if (flush) begin
                s2_valid_reg <= 1'b0;
            end else if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end

            // Output data only moves when the consumer can take it, so it holds during a stall.
            if (s2_adv && s1_valid_reg) begin
                s2_result_reg <= result_next;
                s2_tag_reg    <= s1_tag_reg;
            end
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_result = s2_result_reg;
    assign out_tag    = s2_tag_reg;

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard testbench for cmp_pipe: a WIDTH=32 instance for the main scenarios plus a WIDTH=8 instance.
module tb_cmp_pipe;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_src1;
    logic [W-1:0]  in_src2;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;

    logic          b_flush;
    logic          b_in_valid;
    logic          b_in_ready;
    logic [3:0]    b_in_op;
    logic [7:0]    b_in_src1;
    logic [7:0]    b_in_src2;
    logic [2:0]    b_in_tag;
    logic          b_out_valid;
    logic          b_out_ready;
    logic [7:0]    b_out_result;
    logic [2:0]    b_out_tag;

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    cmp_pipe #(.WIDTH(8), .TAG_W(3)) dut8 (
        .clk(clk), .resetn(resetn), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
        .in_src1(b_in_src1), .in_src2(b_in_src2), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_tag(b_out_tag)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   consumed    = 0;

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         slt;
        r   = '0;
        slt = $signed(a) < $signed(b);
        if (op[0]) r[0] = r[0] | slt;
        if (op[1]) r[0] = r[0] | (a < b);
`ifdef CMP_MINMAX_EN
        if (op[2]) r = r | (slt ? a : b);
        if (op[3]) r = r | (slt ? b : a);
`endif
        return r;
    endfunction

    // Settle combinational paths, then account for both handshakes of the current cycle.
    task automatic sample();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            consumed++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_spurious: got result %h tag %0d, required no output", out_result, out_tag);
            end else begin
                e = sb.pop_front();
                $display("out  tag=%0d result=%h (expected tag=%0d result=%h)", out_tag, out_result, e.tag, e.res);
                if (out_result !== e.res || out_tag !== e.tag) begin
                    miscompares++;
                    $display("FAIL sb_result: got %h/tag %0d, required %h/tag %0d", out_result, out_tag, e.res, e.tag);
                end
            end
        end
        if (flush) sb.delete();
        if (in_valid && in_ready) begin
            sb.push_back('{tag: in_tag, res: model(in_op, in_src1, in_src2)});
            $display("in   tag=%0d op=%b src1=%h src2=%h", in_tag, in_op, in_src1, in_src2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        drive(op, a, b, tag);
        sample();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            tick();
        end
    endtask

    task automatic check_empty(input string name);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d results still pending, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b result=%h tag=%0d, required 0/0/0", out_valid, out_result, out_tag);
        end
        resetn = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_slt();
        out_ready = 1'b1;
        drive(4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3);
        sample();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL slt_accept: in_ready got %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        sample();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL slt_early: out_valid got %b one edge after accept, required 0", out_valid);
        end
        tick();
        sample();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'd1 || out_tag !== 5'd3) begin
            miscompares++;
            $display("FAIL slt_latency: got valid=%b result=%h tag=%0d, required 1/1/3", out_valid, out_result, out_tag);
        end
        tick();
        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4);
        drain(3);
        check_empty("slt_drain");
    endtask

    task automatic test_boundaries();
        out_ready = 1'b1;
        issue(4'b0001, 32'h8000_0000, 32'h7FFF_FFFF, 5'd5);
        issue(4'b0001, 32'h7FFF_FFFF, 32'h8000_0000, 5'd6);
        issue(4'b0001, 32'h1234_5678, 32'h1234_5678, 5'd7);
        issue(4'b0010, 32'h1234_5678, 32'h1234_5678, 5'd8);
        issue(4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd9);
        issue(4'b0000, 32'h0000_0000, 32'h0000_0005, 5'd10);
        drain(3);
        check_empty("bound_drain");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i < 8) drive((i % 2 == 1) ? 4'b0010 : 4'b0001, $urandom, $urandom, TW'(i + 16));
            else in_valid = 1'b0;
            sample();
            vectors++;
            if (out_valid !== (i >= 2 && i <= 9)) begin
                miscompares++;
                $display("FAIL b2b_valid: cycle %0d out_valid got %b, required %b", i, out_valid, (i >= 2 && i <= 9));
            end
            if (i < 8) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready: cycle %0d in_ready got %b, required 1", i, in_ready);
                end
            end
            tick();
        end
        check_empty("b2b_drain");
    endtask

    task automatic test_stall();
        int            idx;
        int            start;
        bit            done;
        logic [W-1:0]  held_res;
        logic [TW-1:0] held_tag;
        idx      = 0;
        start    = consumed;
        done     = 1'b0;
        held_res = '0;
        held_tag = '0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (idx < 6) drive(4'b0001, $urandom, $urandom, TW'(idx + 24));
            else in_valid = 1'b0;
            sample();
            if (in_valid && in_ready) idx++;
            if (cyc >= 3 && cyc <= 6) begin
                vectors++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_full: cycle %0d in_ready=%b out_valid=%b, required 0/1", cyc, in_ready, out_valid);
                end
            end
            if (cyc == 3) begin
                held_res = out_result;
                held_tag = out_tag;
            end else if (cyc > 3 && cyc <= 6) begin
                vectors++;
                if (out_result !== held_res || out_tag !== held_tag) begin
                    miscompares++;
                    $display("FAIL stall_stable: cycle %0d got %h/%0d, required %h/%0d", cyc, out_result, out_tag, held_res, held_tag);
                end
            end
            tick();
            if (idx == 6 && consumed - start == 6) done = 1'b1;
        end
        out_ready = 1'b1;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL stall_timeout: consumed %0d of 6 within budget", consumed - start);
        end
        check_empty("stall_drain");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        issue(4'b0001, 32'h0000_0001, 32'h0000_0002, 5'd11);
        issue(4'b0001, 32'h0000_0002, 32'h0000_0001, 5'd12);
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(4'b0010, 32'h0000_0000, 32'h0000_0009, 5'd13);
        sample();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: in_ready got %b, required 0", in_ready);
        end
        tick();
        flush = 1'b0;
        drive(4'b0010, 32'h0000_0003, 32'h0000_0004, 5'd14);
        sample();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_kill: out_valid got %b, required 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        drain(3);
        check_empty("flush_drain");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        issue(4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd21);
        issue(4'b0010, 32'h0000_0000, 32'h0000_0001, 5'd22);
        sample();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_prefill: out_valid got %b, required 1", out_valid);
        end
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL arst_outputs: got valid=%b result=%h tag=%0d, required 0/0/0", out_valid, out_result, out_tag);
        end
        sb.delete();
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL arst_stale: cycle %0d out_valid got %b, required 0", i, out_valid);
            end
            tick();
        end
        check_empty("arst_drain");
    endtask

    task automatic test_minmax();
        out_ready = 1'b1;
        issue(4'b0100, 32'hFFFF_FFFB, 32'h0000_0003, 5'd1);
        issue(4'b1000, 32'hFFFF_FFFB, 32'h0000_0003, 5'd2);
        issue(4'b0100, 32'h0000_0007, 32'h8000_0000, 5'd3);
        drain(3);
        check_empty("minmax_drain");
    endtask

    task automatic test_width8();
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_op     = 4'b0010;
        b_in_src1   = 8'h01;
        b_in_src2   = 8'hFF;
        b_in_tag    = 3'd7;
        #1;
        vectors++;
        if (b_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL w8_accept: in_ready got %b, required 1", b_in_ready);
        end
        tick();
        b_in_valid = 1'b0;
        #1;
        vectors++;
        if (b_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL w8_early: out_valid got %b, required 0", b_out_valid);
        end
        tick();
        #1;
        vectors++;
        if (b_out_valid !== 1'b1 || b_out_result !== 8'h01 || b_out_tag !== 3'd7) begin
            miscompares++;
            $display("FAIL w8_sltu: got valid=%b result=%h tag=%0d, required 1/01/7", b_out_valid, b_out_result, b_out_tag);
        end
        $display("w8   tag=%0d result=%h", b_out_tag, b_out_result);
        tick();
    endtask

    initial begin
        resetn      = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_op       = '0;
        in_src1     = '0;
        in_src2     = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_op     = '0;
        b_in_src1   = '0;
        b_in_src2   = '0;
        b_in_tag    = '0;
        b_out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_slt();
        test_boundaries();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_minmax();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmp_pipe.md
# cmp_pipe

Parametrised, two-stage pipelined set-less-than/compare unit for the execute stage. Accepts one operand pair per cycle under a valid/ready handshake and returns a WIDTH-bit result (SLT, SLTU, optionally signed MIN/MAX) two cycles later with a pass-through tag. It replaces the single-cycle combinational compare path where timing or back-pressure from the writeback stage requires registering.

## Interface
- WIDTH, 32, operand and result width (≥2)
- TAG_W, 5, tag width carried alongside each operation (destination register number)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  4  one-hot op: [0] SLT, [1] SLTU, [2] MIN (signed), [3] MAX (signed)
- in_src1  in  WIDTH  operand rj
- in_src2  in  WIDTH  operand rk
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  compare result
- out_tag  out  TAG_W  tag of the result

## Operation
- Stage 1 (S1): registers op, src1, src2, tag, and s1_valid on accept (in_valid & in_ready).
- Stage 2 (S2): registers the computed result, tag, and s2_valid from S1; drives out_* directly from registers.
- Arithmetic: {cout, diff} = src1 + ~src2 + 1, WIDTH+1 bits.
  - lt_u = ~cout.
  - lt_s = (src1[MSB] & ~src2[MSB]) | (~(src1[MSB] ^ src2[MSB]) & diff[MSB]).
- SLT result is {0, lt_s}, SLTU result is {0, lt_u}, MIN is lt_s ? src1 : src2, MAX is lt_s ? src2 : src1.
- Multi-hot op: the result is the bitwise OR of every selected result. An all-zero op gives result 0 and still flows through with valid and tag.
- Advance rules:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv & ~flush.
- On s2_adv, S2 loads from S1. s2_valid takes s1_valid.
- On s1_adv, S1 loads the input. s1_valid takes in_valid & ~flush.
- Stall: while out_valid & ~out_ready, out_result and out_tag hold stable. S1 holds if also full.
- Flush: on the next edge s1_valid = s2_valid = 0. Input offered during flush is not accepted. A result handshaked (out_valid & out_ready) in the flush cycle counts as consumed.
- Reset (resetn low, asynchronous): s1_valid = s2_valid = 0, out_valid = 0, out_result = 0, out_tag = 0, all S1 data registers 0. in_ready = 1 once resetn is high and flush is low.

## Timing
- Latency: accept at edge N, out_valid = 1 after edge N+1 (visible in cycle N+1 to N+2 window). Result registered at the second edge after the input was presented.
- Throughput: one op per cycle with out_ready held high. No bubble is inserted when S2 drains and S1 refills in the same cycle.
- Capacity: 2 ops in flight. in_ready deasserts only when both stages are full and out_ready = 0.
- in_ready depends combinationally on out_ready, s1_valid, s2_valid, and flush. out_* have no combinational input paths.
- Reset released mid-stream: the pipeline restarts empty and no stale result appears.

## Configuration
- CMP_MINMAX_EN defined: in_op[2] and in_op[3] are decoded, and MIN/MAX results are computed as above.
- CMP_MINMAX_EN undefined: in_op[3:2] are ignored and contribute 0 to the OR, and the MIN/MAX muxes are not synthesised.
  - in_op = 4'b0100 yields out_result = 0.

## Test plan
- Reset, then WIDTH=32, SLT, src1=0xFFFFFFFF, src2=0x00000001, tag 3 → out_valid 2 edges after accept, out_result=1, out_tag=3. Same operands with SLTU → 0.
- Signed boundaries: SLT 0x80000000 vs 0x7FFFFFFF → 1; SLT 0x7FFFFFFF vs 0x80000000 → 0; SLT and SLTU with equal operands → 0.
- Back-to-back 8 ops, out_ready=1 → 8 results on consecutive cycles in order. Hold out_ready=0 for 4 cycles mid-stream → in_ready falls after 2 in flight, out_result is stable, and no op is lost or duplicated.
- Flush with both stages full and in_valid=1 → next cycle out_valid=0, the offered op is not accepted, and the following op's result is the next one out.
- Assert resetn low asynchronously mid-cycle with 2 ops in flight → out_valid, out_result, and out_tag are 0 immediately, with no stale result after release.
- With CMP_MINMAX_EN: MIN(-5, 3) → 0xFFFFFFFB and MAX(-5, 3) → 3. Without CMP_MINMAX_EN: the same ops → 0. Also run WIDTH=8: SLTU 0x01 vs 0xFF → 1.
